// File: rtl/sm_scoreboard_ctrl_pkg.sv
// Shared types and constants for the SM issue scoreboard / WMMA sequencer.
package sm_scoreboard_ctrl_pkg;

    localparam int unsigned NUM_SP    = 4;
    localparam int unsigned NREG      = 16;
    localparam int unsigned NPRED     = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned REG_AW    = 4;
    localparam int unsigned PRED_AW   = 2;
    localparam int unsigned NSRC      = 3;
    localparam int unsigned WMMA_REGS = 4;

    // WMMA writes an aligned group of four registers; low address bits are dropped
    localparam logic [REG_AW-1:0] WMMA_BASE_MASK = 4'b1100;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_START = 2'd2,
        SB_WAIT  = 2'd3
    } sb_state_e;

    function automatic logic [REG_AW-1:0] wmma_base(input logic [REG_AW-1:0] rd);
        return rd & WMMA_BASE_MASK;
    endfunction

endpackage

// File: rtl/sm_scoreboard_ctrl_if.sv
// Decoder / SP-core / tensor-core side bundle of the scoreboard controller.
interface sm_scoreboard_ctrl_if;
    import sm_scoreboard_ctrl_pkg::*;

    logic                        id_valid;
    logic                        id_is_wmma;
    logic [NSRC*REG_AW-1:0]      id_src_addr;
    logic [NSRC-1:0]             id_src_use;
    logic                        id_pred_rd_use;
    logic [PRED_AW-1:0]          id_pred_rd_sel;
    logic                        id_rf_we;
    logic                        id_pred_we;
    logic [REG_AW-1:0]           id_rD_addr;
    logic [PRED_AW-1:0]          id_pred_wr_sel;
    logic                        br_flush;
    logic [NUM_SP-1:0]           sp_ex_busy;
    logic                        wb_valid;
    logic                        wb_rf_we;
    logic [REG_AW-1:0]           wb_rD_addr;
    logic                        wb_pred_we;
    logic [PRED_AW-1:0]          wb_pred_sel;
    logic                        tc_done;

    logic                        stall;
    logic                        flush_id;
    logic                        id_issue;
    logic                        tc_start;
    logic [REG_AW-1:0]           tc_rD_base;
    logic [NREG-1:0]             gpr_pending;
    logic [NPRED-1:0]            pred_pending;

    modport master (
        output id_valid, id_is_wmma, id_src_addr, id_src_use, id_pred_rd_use, id_pred_rd_sel,
               id_rf_we, id_pred_we, id_rD_addr, id_pred_wr_sel, br_flush, sp_ex_busy,
               wb_valid, wb_rf_we, wb_rD_addr, wb_pred_we, wb_pred_sel, tc_done,
        input  stall, flush_id, id_issue, tc_start, tc_rD_base, gpr_pending, pred_pending
    );

    modport slave (
        input  id_valid, id_is_wmma, id_src_addr, id_src_use, id_pred_rd_use, id_pred_rd_sel,
               id_rf_we, id_pred_we, id_rD_addr, id_pred_wr_sel, br_flush, sp_ex_busy,
               wb_valid, wb_rf_we, wb_rD_addr, wb_pred_we, wb_pred_sel, tc_done,
        output stall, flush_id, id_issue, tc_start, tc_rD_base, gpr_pending, pred_pending
    );

endinterface

// File: rtl/sm_scoreboard_ctrl_hazard_chk.sv
// RAW/WAW check of the ID instruction against the pending GPR and predicate vectors.
module sm_scoreboard_ctrl_hazard_chk
    import sm_scoreboard_ctrl_pkg::*;
(
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] src_addr,
    input  logic [NSRC-1:0]        src_use,
    input  logic                   pred_rd_use,
    input  logic [PRED_AW-1:0]     pred_rd_sel,
    input  logic                   rf_we,
    input  logic [REG_AW-1:0]      rd_addr,
    input  logic                   pred_we,
    input  logic [PRED_AW-1:0]     pred_wr_sel,
    input  logic [NREG-1:0]        gpr_pending,
    input  logic [NPRED-1:0]       pred_pending,
    output logic                   hazard_c
);

    logic src_raw_c;

    always_comb begin
        src_raw_c = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (src_use[i] && gpr_pending[src_addr[REG_AW*i +: REG_AW]]) begin
                src_raw_c = 1'b1;
            end
        end
    end

    assign hazard_c = id_valid & ( src_raw_c
                                 | (pred_rd_use & pred_pending[pred_rd_sel])
                                 | (rf_we       & gpr_pending[rd_addr])
                                 | (pred_we     & pred_pending[pred_wr_sel]));

endmodule

// File: rtl/sm_scoreboard_ctrl.sv
// SM issue controller: GPR/predicate scoreboard, shared stall/flush_id and WMMA sequencing.
module sm_scoreboard_ctrl
    import sm_scoreboard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sm_scoreboard_ctrl_if.slave  bus
);

    sb_state_e          state_q, state_d;
    logic [NREG-1:0]    gpr_q, gpr_d, gpr_set_c, gpr_clr_c;
    logic [NPRED-1:0]   pred_q, pred_d, pred_set_c, pred_clr_c;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [REG_AW-1:0]  base_q, id_base_c;

    logic stall_c, hazard_c, idle_c, start_c, wait_c;
    logic scalar_issue_c, issue_c, dec_c;

    sm_scoreboard_ctrl_hazard_chk u_hazard_chk (
        .id_valid     (bus.id_valid),
        .src_addr     (bus.id_src_addr),
        .src_use      (bus.id_src_use),
        .pred_rd_use  (bus.id_pred_rd_use),
        .pred_rd_sel  (bus.id_pred_rd_sel),
        .rf_we        (bus.id_rf_we),
        .rd_addr      (bus.id_rD_addr),
        .pred_we      (bus.id_pred_we),
        .pred_wr_sel  (bus.id_pred_wr_sel),
        .gpr_pending  (gpr_q),
        .pred_pending (pred_q),
        .hazard_c     (hazard_c)
    );

    assign stall_c   = |bus.sp_ex_busy;
    assign idle_c    = (state_q == SB_IDLE);
    assign start_c   = (state_q == SB_START);
    assign wait_c    = (state_q == SB_WAIT);
    assign id_base_c = wmma_base(bus.id_rD_addr);

    assign scalar_issue_c = bus.id_valid & ~bus.id_is_wmma & ~hazard_c & ~stall_c
                          & ~bus.br_flush & idle_c;
    assign issue_c        = scalar_issue_c | start_c;
    assign dec_c          = bus.wb_valid & (inflight_q != '0);

    assign bus.stall        = stall_c;
    assign bus.id_issue     = issue_c;
    assign bus.flush_id     = bus.br_flush | start_c | (bus.id_valid & ~issue_c & ~stall_c);
    assign bus.tc_start     = start_c;
    assign bus.tc_rD_base   = start_c ? id_base_c : base_q;
    assign bus.gpr_pending  = gpr_q;
    assign bus.pred_pending = pred_q;

    // Pending-bit set/clear requests; set is applied after clear so it wins
    always_comb begin
        gpr_set_c  = '0;
        gpr_clr_c  = '0;
        pred_set_c = '0;
        pred_clr_c = '0;
        if (scalar_issue_c && bus.id_rf_we)   gpr_set_c[bus.id_rD_addr]      = 1'b1;
        if (scalar_issue_c && bus.id_pred_we) pred_set_c[bus.id_pred_wr_sel] = 1'b1;
        if (start_c)                          gpr_set_c[id_base_c +: WMMA_REGS] = '1;
        if (bus.wb_valid && bus.wb_rf_we)     gpr_clr_c[bus.wb_rD_addr]      = 1'b1;
        if (bus.wb_valid && bus.wb_pred_we)   pred_clr_c[bus.wb_pred_sel]    = 1'b1;
        if (wait_c && bus.tc_done)            gpr_clr_c[base_q +: WMMA_REGS] = '1;
        gpr_d  = (gpr_q  & ~gpr_clr_c)  | gpr_set_c;
        pred_d = (pred_q & ~pred_clr_c) | pred_set_c;
    end

    // In-flight counter; a WB with nothing outstanding leaves it at zero
    always_comb begin
        inflight_d = inflight_q;
        if (scalar_issue_c && !dec_c) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!scalar_issue_c && dec_c) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // WMMA sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: begin
                if (bus.id_valid && bus.id_is_wmma && !hazard_c && !bus.br_flush) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (bus.br_flush) begin
                    state_d = SB_IDLE;
                end else if ((inflight_q == '0) && !stall_c) begin
                    state_d = SB_START;
                end
            end
            SB_START: state_d = SB_WAIT;
            SB_WAIT: begin
                if (bus.tc_done) state_d = SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SB_IDLE;
            gpr_q      <= '0;
            pred_q     <= '0;
            inflight_q <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            gpr_q      <= gpr_d;
            pred_q     <= pred_d;
            inflight_q <= inflight_d;
            if (start_c) base_q <= id_base_c;
        end
    end

    // Writeback with no outstanding instruction is a protocol error upstream
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(bus.wb_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_sm_scoreboard_ctrl.sv
// Directed bench for sm_scoreboard_ctrl with hand-computed expectations.
module tb_sm_scoreboard_ctrl;
    import sm_scoreboard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned total = 0;
    int unsigned bad   = 0;

    sm_scoreboard_ctrl_if bus();

    sm_scoreboard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.id_valid = 1'b0; bus.id_is_wmma = 1'b0; bus.id_src_addr = '0; bus.id_src_use = '0;
        bus.id_pred_rd_use = 1'b0; bus.id_pred_rd_sel = '0; bus.id_rf_we = 1'b0;
        bus.id_pred_we = 1'b0; bus.id_rD_addr = '0; bus.id_pred_wr_sel = '0;
        bus.br_flush = 1'b0; bus.sp_ex_busy = '0; bus.wb_valid = 1'b0; bus.wb_rf_we = 1'b0;
        bus.wb_rD_addr = '0; bus.wb_pred_we = 1'b0; bus.wb_pred_sel = '0; bus.tc_done = 1'b0;
    endtask

    task automatic id_scalar(input logic rf_we, input logic [3:0] rd,
                             input logic [2:0] src_use, input logic [11:0] src);
        bus.id_valid = 1'b1; bus.id_is_wmma = 1'b0; bus.id_rf_we = rf_we; bus.id_rD_addr = rd;
        bus.id_src_use = src_use; bus.id_src_addr = src; bus.id_pred_we = 1'b0;
        bus.id_pred_rd_use = 1'b0;
    endtask

    task automatic id_wmma(input logic [3:0] rd);
        bus.id_valid = 1'b1; bus.id_is_wmma = 1'b1; bus.id_rf_we = 1'b1; bus.id_rD_addr = rd;
        bus.id_src_use = '0; bus.id_pred_we = 1'b0; bus.id_pred_rd_use = 1'b0;
    endtask

    task automatic wb_gpr(input logic [3:0] rd);
        bus.wb_valid = 1'b1; bus.wb_rf_we = 1'b1; bus.wb_rD_addr = rd; bus.wb_pred_we = 1'b0;
    endtask

    task automatic wb_off();
        bus.wb_valid = 1'b0; bus.wb_rf_we = 1'b0; bus.wb_pred_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_gpr",   32'(bus.gpr_pending),  32'h0);
        chk("rst_pred",  32'(bus.pred_pending), 32'h0);
        chk("rst_tc",    32'(bus.tc_start),     32'h0);
        chk("rst_issue", 32'(bus.id_issue),     32'h0);
        chk("rst_flush", 32'(bus.flush_id),     32'h0);
        chk("rst_stall", 32'(bus.stall),        32'h0);

        // RAW: ADD r3, then consumer of r3 held until r3 WB
        id_scalar(1'b1, 4'd3, 3'b000, 12'h000); #1;
        chk("raw_prod_issue", 32'(bus.id_issue), 32'h1);
        tick();
        chk("raw_prod_pend", 32'(bus.gpr_pending), 32'h0008);
        id_scalar(1'b1, 4'd4, 3'b001, 12'h003); #1;
        chk("raw_hold_issue", 32'(bus.id_issue), 32'h0);
        chk("raw_hold_flush", 32'(bus.flush_id), 32'h1);
        tick();
        chk("raw_hold2_issue", 32'(bus.id_issue), 32'h0);
        wb_gpr(4'd3); #1;
        chk("raw_wbcyc_issue", 32'(bus.id_issue), 32'h0);
        tick(); wb_off(); #1;
        chk("raw_clr_pend",  32'(bus.gpr_pending), 32'h0);
        chk("raw_issue",     32'(bus.id_issue),    32'h1);
        chk("raw_issue_fl",  32'(bus.flush_id),    32'h0);
        tick(); bus.id_valid = 1'b0; #1;
        chk("raw_r4_pend", 32'(bus.gpr_pending), 32'h0010);
        wb_gpr(4'd4); tick(); wb_off(); #1;
        chk("raw_r4_clr", 32'(bus.gpr_pending), 32'h0);

        // WAW on r5
        id_scalar(1'b1, 4'd5, 3'b000, 12'h000);
        tick();
        chk("waw_hold_issue", 32'(bus.id_issue),    32'h0);
        chk("waw_hold_flush", 32'(bus.flush_id),    32'h1);
        chk("waw_pend",       32'(bus.gpr_pending), 32'h0020);
        tick();
        chk("waw_pend2", 32'(bus.gpr_pending), 32'h0020);
        wb_gpr(4'd5); #1;
        chk("waw_wbcyc_issue", 32'(bus.id_issue), 32'h0);
        tick(); wb_off(); #1;
        chk("waw_clr",   32'(bus.gpr_pending), 32'h0);
        chk("waw_issue", 32'(bus.id_issue),    32'h1);
        tick(); bus.id_valid = 1'b0; #1;
        chk("waw_reset_pend", 32'(bus.gpr_pending), 32'h0020);
        wb_gpr(4'd5); tick(); wb_off();

        // Same-cycle set of r7 and WB clear of r7 with r2 pending: set wins
        id_scalar(1'b1, 4'd2, 3'b000, 12'h000); tick();
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); tick();
        id_scalar(1'b1, 4'd7, 3'b000, 12'h000); wb_gpr(4'd7); #1;
        chk("sc_issue", 32'(bus.id_issue), 32'h1);
        tick(); bus.id_valid = 1'b0; wb_off(); #1;
        chk("sc_pend", 32'(bus.gpr_pending), 32'h0084);
        wb_gpr(4'd2); tick();
        wb_gpr(4'd7); tick(); wb_off(); #1;
        chk("sc_drained", 32'(bus.gpr_pending), 32'h0);

        // Predicate write then guarded read of the same predicate
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); bus.id_pred_we = 1'b1; bus.id_pred_wr_sel = 2'd1;
        tick();
        chk("pred_pend", 32'(bus.pred_pending), 32'h2);
        bus.id_pred_we = 1'b0; bus.id_pred_rd_use = 1'b1; bus.id_pred_rd_sel = 2'd1; #1;
        chk("pred_hold", 32'(bus.id_issue), 32'h0);
        bus.wb_valid = 1'b1; bus.wb_pred_we = 1'b1; bus.wb_pred_sel = 2'd1;
        tick(); wb_off(); #1;
        chk("pred_clr",   32'(bus.pred_pending), 32'h0);
        chk("pred_issue", 32'(bus.id_issue),     32'h1);
        tick(); clr_in();
        bus.wb_valid = 1'b1; tick(); wb_off();

        // Stall from one busy lane for five cycles
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); bus.sp_ex_busy = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_on",    32'(bus.stall),    32'h1);
            chk("stall_issue", 32'(bus.id_issue), 32'h0);
            chk("stall_flush", 32'(bus.flush_id), 32'h0);
            tick();
        end
        bus.sp_ex_busy = '0; #1;
        chk("stall_off",   32'(bus.stall),    32'h0);
        chk("stall_issue", 32'(bus.id_issue), 32'h1);
        tick(); bus.id_valid = 1'b0;
        bus.wb_valid = 1'b1; tick(); wb_off();

        // Branch flush kills ID
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); bus.br_flush = 1'b1; #1;
        chk("br_issue", 32'(bus.id_issue), 32'h0);
        chk("br_flush", 32'(bus.flush_id), 32'h1);
        bus.br_flush = 1'b0; bus.id_valid = 1'b0; #1;

        // WMMA rD=9 with two instructions in flight
        id_scalar(1'b1, 4'd1, 3'b000, 12'h000); tick();
        id_scalar(1'b1, 4'd2, 3'b000, 12'h000); tick();
        id_wmma(4'd9); #1;
        chk("wm_idle_issue", 32'(bus.id_issue), 32'h0);
        chk("wm_idle_flush", 32'(bus.flush_id), 32'h1);
        tick();
        chk("wm_drain_tc", 32'(bus.tc_start), 32'h0);
        wb_gpr(4'd1); tick();
        chk("wm_drain1_tc", 32'(bus.tc_start), 32'h0);
        wb_gpr(4'd2); tick(); wb_off(); #1;
        chk("wm_drain2_tc", 32'(bus.tc_start), 32'h0);
        tick();
        chk("wm_start_tc",    32'(bus.tc_start),   32'h1);
        chk("wm_start_base",  32'(bus.tc_rD_base), 32'h8);
        chk("wm_start_issue", 32'(bus.id_issue),   32'h1);
        chk("wm_start_flush", 32'(bus.flush_id),   32'h1);
        tick();
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); #1;
        chk("wm_wait_tc",    32'(bus.tc_start),    32'h0);
        chk("wm_wait_pend",  32'(bus.gpr_pending), 32'h0F00);
        chk("wm_wait_issue", 32'(bus.id_issue),    32'h0);
        tick();
        chk("wm_wait_pend2", 32'(bus.gpr_pending), 32'h0F00);
        bus.id_valid = 1'b0; bus.tc_done = 1'b1;
        tick(); bus.tc_done = 1'b0; #1;
        chk("wm_done_pend", 32'(bus.gpr_pending), 32'h0);
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); #1;
        chk("wm_idle_again", 32'(bus.id_issue), 32'h1);
        bus.id_valid = 1'b0; #1;

        // Branch flush while draining squashes the WMMA
        id_wmma(4'd6); tick();
        bus.br_flush = 1'b1; #1;
        chk("wmf_flush", 32'(bus.flush_id), 32'h1);
        tick(); bus.br_flush = 1'b0; bus.id_valid = 1'b0; #1;
        chk("wmf_no_tc",  32'(bus.tc_start),    32'h0);
        chk("wmf_pend",   32'(bus.gpr_pending), 32'h0);
        tick();
        chk("wmf_no_tc2", 32'(bus.tc_start),    32'h0);
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); #1;
        chk("wmf_idle", 32'(bus.id_issue), 32'h1);
        bus.id_valid = 1'b0; #1;

        // Reset while in WAIT
        id_wmma(4'd2); tick(); tick(); tick();
        bus.id_valid = 1'b0; #1;
        chk("rw_wait_pend", 32'(bus.gpr_pending), 32'h000F);
        rst = 1'b1; bus.sp_ex_busy = 4'b0001;
        tick(); rst = 1'b0; #1;
        chk("rw_pend",  32'(bus.gpr_pending), 32'h0);
        chk("rw_tc",    32'(bus.tc_start),    32'h0);
        chk("rw_stall", 32'(bus.stall),       32'h1);
        chk("rw_base",  32'(bus.tc_rD_base),  32'h0);
        bus.sp_ex_busy = '0;
        id_scalar(1'b0, 4'd0, 3'b000, 12'h000); #1;
        chk("rw_stall_off", 32'(bus.stall),    32'h0);
        chk("rw_idle",      32'(bus.id_issue), 32'h1);
        bus.id_valid = 1'b0; #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
